// File: rtl/mdio_responder_pkg.sv
// Shared MDIO frame constants for the clause-22 management responder.
// Covers the opcodes, FSM states, frame bit positions and the read-only register guard.
package mdio_responder_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ST2,
    ST_OP,
    ST_PHYAD,
    ST_REGAD,
    ST_TA,
    ST_WDATA,
    ST_RDATA,
    ST_SKIP
  } state_e;

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  // 1-based frame bit index (ST first bit = 1) of the last bit of each field
  localparam logic [5:0] POS_OP_END    = 6'd4;
  localparam logic [5:0] POS_PHYAD_END = 6'd9;
  localparam logic [5:0] POS_REGAD_END = 6'd14;
  localparam logic [5:0] POS_TA_END    = 6'd16;
  localparam logic [5:0] POS_FRAME_END = 6'd32;

  localparam logic [5:0] PRE_SAT   = 6'd63;
  localparam logic [4:0] REG_ID_HI = 5'd2;
  localparam logic [4:0] REG_ID_LO = 5'd3;

  function automatic logic is_ro_reg(input logic [4:0] addr);
    return (addr == REG_ID_HI) || (addr == REG_ID_LO);
  endfunction

endpackage

// File: rtl/mdio_regfile.sv
// 32x16 management register file with fixed PHY identifier words in regs 2 and 3.
// Provides one write port and one combinational read port.
module mdio_regfile
  import mdio_responder_pkg::*;
#(
  parameter logic [15:0] ID_HI = 16'h0141,
  parameter logic [15:0] ID_LO = 16'h0CB1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [4:0]  raddr,
  output logic [15:0] rdata
);

  logic [15:0] mem_r [32];

  // Register array: identifier words restored on reset and never overwritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem_r[i] <= 16'h0000;
      mem_r[REG_ID_HI] <= ID_HI;
      mem_r[REG_ID_LO] <= ID_LO;
    end else if (we && !is_ro_reg(waddr)) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: decodes ST|OP|PHYAD|REGAD|TA|DATA frames sampled on MDC rise,
// commits writes to the register file and drives read data on MDC fall.
module mdio_responder
  import mdio_responder_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'd2,
  parameter int          PRE_MIN  = 0,
  parameter logic [15:0] ID_HI    = 16'h0141,
  parameter logic [15:0] ID_LO    = 16'h0CB1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic        wr_stb,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy
);

  localparam logic [6:0] PRE_MIN_C = 7'(PRE_MIN);

  state_e      state_r;
  logic        mdc_q_r;
  logic [5:0]  pre_cnt_r;
  logic [5:0]  bit_pos_r;
  logic [14:0] sh_r;
  logic [1:0]  op_r;
  logic [4:0]  regad_r;
  logic        drv_act_r;
  logic [4:0]  drv_cnt_r;
  logic [15:0] rd_word_r;
  logic        mdio_out_r;
  logic        mdio_oe_r;
  logic        wr_stb_r;
  logic [4:0]  wr_addr_r;
  logic [15:0] wr_data_r;
  logic        busy_r;

  logic        rise_s;
  logic        fall_s;
  logic [5:0]  nxt_pos_s;
  logic        pre_ok_s;
  logic [15:0] rdata_s;

  assign rise_s    = mdc & ~mdc_q_r;
  assign fall_s    = ~mdc & mdc_q_r;
  assign nxt_pos_s = bit_pos_r + 6'd1;
  // count >= PRE_MIN, phrased so that PRE_MIN = 0 is not a constant compare
  assign pre_ok_s  = ({1'b0, pre_cnt_r} + 7'd1) > PRE_MIN_C;

  mdio_regfile #(
    .ID_HI(ID_HI),
    .ID_LO(ID_LO)
  ) u_regfile (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_stb_r),
    .waddr(wr_addr_r),
    .wdata(wr_data_r),
    .raddr(regad_r),
    .rdata(rdata_s)
  );

  // MDC edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdc_q_r <= 1'b0;
    else        mdc_q_r <= mdc;
  end

  // Frame FSM on MDC rise, read-data driver on MDC fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pre_cnt_r  <= 6'd0;
      bit_pos_r  <= 6'd0;
      sh_r       <= 15'd0;
      op_r       <= 2'b00;
      regad_r    <= 5'd0;
      drv_act_r  <= 1'b0;
      drv_cnt_r  <= 5'd0;
      rd_word_r  <= 16'h0000;
      mdio_out_r <= 1'b0;
      mdio_oe_r  <= 1'b0;
      wr_stb_r   <= 1'b0;
      wr_addr_r  <= 5'd0;
      wr_data_r  <= 16'h0000;
      busy_r     <= 1'b0;
    end else begin
      wr_stb_r <= 1'b0;
      if (rise_s) begin
        sh_r      <= {sh_r[13:0], mdio_in};
        bit_pos_r <= nxt_pos_s;
        case (state_r)
          ST_IDLE: begin
            bit_pos_r <= 6'd0;
            if (mdio_in) begin
              if (pre_cnt_r != PRE_SAT) pre_cnt_r <= pre_cnt_r + 6'd1;
            end else if (pre_ok_s) begin
              state_r   <= ST_ST2;
              bit_pos_r <= 6'd1;
              pre_cnt_r <= 6'd0;
            end else begin
              pre_cnt_r <= 6'd0;
            end
          end
          ST_ST2: state_r <= mdio_in ? ST_OP : ST_IDLE;
          ST_OP: begin
            if (nxt_pos_s == POS_OP_END) begin
              op_r <= {sh_r[0], mdio_in};
              if (({sh_r[0], mdio_in} == OP_WR) || ({sh_r[0], mdio_in} == OP_RD)) state_r <= ST_PHYAD;
              else state_r <= ST_SKIP;
            end
          end
          ST_PHYAD: begin
            if (nxt_pos_s == POS_PHYAD_END) begin
              if ({sh_r[3:0], mdio_in} == PHY_ADDR) begin
                state_r <= ST_REGAD;
                busy_r  <= 1'b1;
              end else begin
                state_r <= ST_SKIP;
              end
            end
          end
          ST_REGAD: begin
            if (nxt_pos_s == POS_REGAD_END) begin
              regad_r <= {sh_r[3:0], mdio_in};
              state_r <= ST_TA;
              if (op_r == OP_RD) begin
                drv_act_r <= 1'b1;
                drv_cnt_r <= 5'd0;
              end
            end
          end
          ST_TA: begin
            if (nxt_pos_s == POS_TA_END) state_r <= (op_r == OP_WR) ? ST_WDATA : ST_RDATA;
          end
          ST_WDATA: begin
            if (nxt_pos_s == POS_FRAME_END) begin
              wr_stb_r  <= 1'b1;
              wr_addr_r <= regad_r;
              wr_data_r <= {sh_r, mdio_in};
              busy_r    <= 1'b0;
              state_r   <= ST_IDLE;
            end
          end
          ST_RDATA, ST_SKIP: begin
            if (nxt_pos_s == POS_FRAME_END) begin
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
      // Falls after REGAD: TA Z, TA zero (latch word), 16 data bits, release
      if (fall_s && drv_act_r) begin
        drv_cnt_r <= drv_cnt_r + 5'd1;
        if (drv_cnt_r == 5'd0) begin
          mdio_oe_r  <= 1'b0;
          mdio_out_r <= 1'b0;
        end else if (drv_cnt_r == 5'd1) begin
          mdio_oe_r  <= 1'b1;
          mdio_out_r <= 1'b0;
          rd_word_r  <= rdata_s;
        end else if (drv_cnt_r <= 5'd17) begin
          mdio_out_r <= rd_word_r[4'(5'd17 - drv_cnt_r)];
        end else begin
          mdio_oe_r  <= 1'b0;
          mdio_out_r <= 1'b0;
          drv_act_r  <= 1'b0;
        end
      end
    end
  end

  assign mdio_out = mdio_out_r;
  assign mdio_oe  = mdio_oe_r;
  assign wr_stb   = wr_stb_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_mdio_responder.sv
// Bit-banged MDIO master (MDC = CLK/4) against two responders (PRE_MIN 0 and 32),
// checked against a register-array model of the management space.
module tb_mdio_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mdc0 = 1'b0;
  logic mdc1 = 1'b0;
  logic mdio_in = 1'b1;
  logic out0, oe0, stb0, busy0, out1, oe1, stb1, busy1;
  logic [4:0]  wa0, wa1;
  logic [15:0] wd0, wd1;

  int total = 0;
  int bad = 0;
  int sel = 0;
  logic [15:0] model [32];

  int wr_cnt = 0;
  int stb_long = 0;
  logic stb_prev = 1'b0;
  logic [4:0]  last_wa = 5'd0;
  logic [15:0] last_wd = 16'h0000;

  logic [15:0] f_rd;
  int   f_oe_bits;
  logic f_ta_ok, f_busy_seen, f_oe_early, f_busy_after;

  always #5 clk = ~clk;

  mdio_responder #(.PHY_ADDR(5'd2), .PRE_MIN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mdc(mdc0), .mdio_in(mdio_in), .mdio_out(out0), .mdio_oe(oe0),
    .wr_stb(stb0), .wr_addr(wa0), .wr_data(wd0), .busy(busy0));

  mdio_responder #(.PHY_ADDR(5'd2), .PRE_MIN(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .mdc(mdc1), .mdio_in(mdio_in), .mdio_out(out1), .mdio_oe(oe1),
    .wr_stb(stb1), .wr_addr(wa1), .wr_data(wd1), .busy(busy1));

  always @(negedge clk) begin
    if (stb0) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= wa0;
      last_wd <= wd0;
    end
    if (stb0 && stb_prev) stb_long <= stb_long + 1;
    stb_prev <= stb0;
  end

  function automatic logic cur_oe();   return (sel == 0) ? oe0 : oe1;     endfunction
  function automatic logic cur_out();  return (sel == 0) ? out0 : out1;   endfunction
  function automatic logic cur_busy(); return (sel == 0) ? busy0 : busy1; endfunction

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mdc_set(input logic v);
    if (sel == 0) mdc0 = v;
    else mdc1 = v;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) model[i] = 16'h0000;
    model[2] = 16'h0141;
    model[3] = 16'h0CB1;
  endtask

  // One MDC period; idx is the 1-based frame bit (0 = preamble). Samples just before the rise.
  task automatic send_bit(input logic b, input int idx);
    logic oe, o;
    mdc_set(1'b0);
    mdio_in = b;
    clk_n(2);
    oe = cur_oe();
    o  = cur_out();
    if (cur_busy()) f_busy_seen = 1'b1;
    if (oe) f_oe_bits++;
    if (oe && idx < 16) f_oe_early = 1'b1;
    if (idx == 16 && !(oe && !o)) f_ta_ok = 1'b0;
    if (idx >= 17) f_rd = {f_rd[14:0], o};
    mdc_set(1'b1);
    clk_n(2);
  endtask

  task automatic do_frame(input logic [31:0] fr, input int pre);
    logic is_rd;
    logic b;
    f_rd = 16'h0000; f_oe_bits = 0; f_ta_ok = 1'b1;
    f_busy_seen = 1'b0; f_oe_early = 1'b0;
    is_rd = (fr[29:28] == 2'b10);
    repeat (pre) send_bit(1'b1, 0);
    for (int i = 0; i < 32; i++) begin
      b = fr[31 - i];
      if (is_rd && i >= 14) b = 1'b1;
      send_bit(b, i + 1);
    end
    mdc_set(1'b0);
    clk_n(2);
    if (cur_oe()) f_oe_bits++;
    f_busy_after = cur_busy();
  endtask

  function automatic logic [31:0] mk_frame(input logic [1:0] op, input logic [4:0] phy,
                                           input logic [4:0] rg, input logic [15:0] d);
    return {2'b01, op, phy, rg, 2'b10, d};
  endfunction

  task automatic test_reset();
    total++; if (oe0 !== 1'b0)    begin bad++; $display("FAIL reset_oe got=%b exp=0", oe0); end
    total++; if (out0 !== 1'b0)   begin bad++; $display("FAIL reset_out got=%b exp=0", out0); end
    total++; if (stb0 !== 1'b0)   begin bad++; $display("FAIL reset_stb got=%b exp=0", stb0); end
    total++; if (wa0 !== 5'd0)    begin bad++; $display("FAIL reset_waddr got=%h exp=0", wa0); end
    total++; if (wd0 !== 16'h0)   begin bad++; $display("FAIL reset_wdata got=%h exp=0", wd0); end
    total++; if (busy0 !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy0); end
  endtask

  task automatic test_read_reg4();
    do_frame(32'h6111FFFF, 0);
    total++; if (f_rd !== model[4]) begin bad++; $display("FAIL rd4_data got=%h exp=%h", f_rd, model[4]); end
    total++; if (f_ta_ok !== 1'b1 || f_oe_early !== 1'b0)
      begin bad++; $display("FAIL rd4_ta ta_ok=%b oe_early=%b exp 1/0", f_ta_ok, f_oe_early); end
    total++; if (f_oe_bits != 17) begin bad++; $display("FAIL rd4_oe_periods got=%0d exp=17", f_oe_bits); end
    total++; if (f_busy_seen !== 1'b1 || f_busy_after !== 1'b0)
      begin bad++; $display("FAIL rd4_busy seen=%b after=%b exp 1/0", f_busy_seen, f_busy_after); end
  endtask

  task automatic test_write();
    int c0;
    c0 = wr_cnt;
    do_frame(32'h51125F1F, 0);
    model[4] = 16'h5F1F;
    total++; if (wr_cnt - c0 != 1 || stb_long != 0)
      begin bad++; $display("FAIL wr_stb pulses=%0d long=%0d exp 1/0", wr_cnt - c0, stb_long); end
    total++; if (last_wa !== 5'd4 || last_wd !== 16'h5F1F)
      begin bad++; $display("FAIL wr_commit got=%h/%h exp=04/5f1f", last_wa, last_wd); end
    total++; if (f_oe_bits != 0) begin bad++; $display("FAIL wr_oe got=%0d exp=0", f_oe_bits); end
    do_frame(32'h6111FFFF, 0);
    total++; if (f_rd !== 16'h5F1F) begin bad++; $display("FAIL wr_readback got=%h exp=5f1f", f_rd); end
  endtask

  task automatic test_ro_regs();
    int c0;
    do_frame(32'h6109FFFF, 0);
    total++; if (f_rd !== 16'h0141) begin bad++; $display("FAIL id_hi got=%h exp=0141", f_rd); end
    do_frame(32'h610DFFFF, 0);
    total++; if (f_rd !== 16'h0CB1) begin bad++; $display("FAIL id_lo got=%h exp=0cb1", f_rd); end
    c0 = wr_cnt;
    do_frame(32'h510AFFFF, 0);
    total++; if (wr_cnt - c0 != 1 || last_wa !== 5'd2 || last_wd !== 16'hFFFF)
      begin bad++; $display("FAIL ro_wr_stb pulses=%0d addr=%h data=%h exp 1/02/ffff", wr_cnt - c0, last_wa, last_wd); end
    do_frame(32'h6109FFFF, 0);
    total++; if (f_rd !== 16'h0141) begin bad++; $display("FAIL ro_reread got=%h exp=0141", f_rd); end
  endtask

  task automatic test_other_phy();
    do_frame(32'h6191FFFF, 0);
    total++; if (f_oe_bits != 0 || f_busy_seen !== 1'b0)
      begin bad++; $display("FAIL other_phy oe=%0d busy=%b exp 0/0", f_oe_bits, f_busy_seen); end
    do_frame(32'h6111FFFF, 0);
    total++; if (f_rd !== model[4]) begin bad++; $display("FAIL after_other got=%h exp=%h", f_rd, model[4]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    int c0;
    d = 16'($urandom);
    do_frame(mk_frame(2'b01, 5'd2, 5'd7, d), 0);
    model[7] = d;
    do_frame(mk_frame(2'b10, 5'd2, 5'd7, 16'hFFFF), 0);
    total++; if (f_rd !== d) begin bad++; $display("FAIL b2b_read got=%h exp=%h", f_rd, d); end
    // illegal opcodes must consume exactly one frame and write nothing
    c0 = wr_cnt;
    do_frame(mk_frame(2'b11, 5'd2, 5'd7, 16'h0000), 0);
    do_frame(mk_frame(2'b00, 5'd2, 5'd7, 16'h1234), 0);
    total++; if (wr_cnt != c0 || f_oe_bits != 0)
      begin bad++; $display("FAIL bad_op writes=%0d oe=%0d exp 0/0", wr_cnt - c0, f_oe_bits); end
    do_frame(mk_frame(2'b10, 5'd2, 5'd7, 16'hFFFF), 0);
    total++; if (f_rd !== d) begin bad++; $display("FAIL after_bad_op got=%h exp=%h", f_rd, d); end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [4:0]  phy, rg;
    logic [15:0] d;
    int c0;
    for (int n = 0; n < 24; n++) begin
      op  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd2;
      rg  = 5'($urandom_range(0, 31));
      d   = 16'($urandom);
      c0  = wr_cnt;
      do_frame(mk_frame(op, phy, rg, d), $urandom_range(0, 3));
      if (phy != 5'd2) begin
        total++; if (f_oe_bits != 0 || wr_cnt != c0)
          begin bad++; $display("FAIL rnd_skip phy=%h oe=%0d writes=%0d exp 0/0", phy, f_oe_bits, wr_cnt - c0); end
      end else if (op == 2'b01) begin
        if (rg != 5'd2 && rg != 5'd3) model[rg] = d;
        total++; if (wr_cnt - c0 != 1 || last_wa !== rg || last_wd !== d)
          begin bad++; $display("FAIL rnd_wr n=%0d pulses=%0d got=%h/%h exp=%h/%h", n, wr_cnt - c0, last_wa, last_wd, rg, d); end
      end else begin
        total++; if (f_rd !== model[rg] || f_oe_bits != 17)
          begin bad++; $display("FAIL rnd_rd n=%0d reg=%0d got=%h oe=%0d exp=%h oe=17", n, rg, f_rd, f_oe_bits, model[rg]); end
      end
    end
  endtask

  task automatic test_preamble();
    sel = 1;
    do_frame(32'h6111FFFF, 31);
    total++; if (f_oe_bits != 0 || f_busy_seen !== 1'b0)
      begin bad++; $display("FAIL pre31 oe=%0d busy=%b exp 0/0", f_oe_bits, f_busy_seen); end
    send_bit(1'b0, 0);
    do_frame(32'h6111FFFF, 32);
    total++; if (f_rd !== 16'h0000 || f_oe_bits != 17 || f_ta_ok !== 1'b1)
      begin bad++; $display("FAIL pre32 got=%h oe=%0d ta=%b exp=0000 oe=17 ta=1", f_rd, f_oe_bits, f_ta_ok); end
    total++; if ({stb1, wa1, wd1} !== 22'd0)
      begin bad++; $display("FAIL pre_wr_out got=%h exp=0", {stb1, wa1, wd1}); end
    mdc_set(1'b0);
    sel = 0;
  endtask

  task automatic test_reset_mid_read();
    do_frame(mk_frame(2'b01, 5'd2, 5'd4, 16'hA5C3), 0);
    model[4] = 16'hA5C3;
    f_rd = 16'h0000; f_oe_bits = 0; f_ta_ok = 1'b1; f_busy_seen = 1'b0; f_oe_early = 1'b0;
    for (int i = 0; i < 23; i++) send_bit((i < 14) ? mk_frame(2'b10, 5'd2, 5'd4, 16'hFFFF) >> (31 - i) : 1'b1, i + 1);
    mdc_set(1'b0);
    mdio_in = 1'b1;
    clk_n(2);
    total++; if (oe0 !== 1'b1 || f_rd[6:0] !== 7'b1010010)
      begin bad++; $display("FAIL mid_read_drive oe=%b bits=%b exp 1/1010010", oe0, f_rd[6:0]); end
    rst_n = 1'b0;
    #1;
    total++; if (oe0 !== 1'b0 || busy0 !== 1'b0)
      begin bad++; $display("FAIL reset_abort oe=%b busy=%b exp 0/0", oe0, busy0); end
    clk_n(2);
    rst_n = 1'b1;
    reset_model();
    clk_n(2);
    do_frame(32'h6111FFFF, 0);
    total++; if (f_rd !== 16'h0000) begin bad++; $display("FAIL post_reset_rd4 got=%h exp=0000", f_rd); end
    do_frame(32'h6109FFFF, 0);
    total++; if (f_rd !== 16'h0141) begin bad++; $display("FAIL post_reset_rd2 got=%h exp=0141", f_rd); end
  endtask

  initial begin
    reset_model();
    clk_n(3);
    test_reset();
    rst_n = 1'b1;
    clk_n(2);
    test_read_reg4();
    test_write();
    test_ro_regs();
    test_other_phy();
    test_back_to_back();
    test_random();
    test_preamble();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
